id_ibuf: RTL and testbench
==========================

# id_ibuf

Parametrised instruction buffer between `ifetch` and `id`. It decouples fetch from decode stalls such as load-use hazards and multi-cycle ALU ops. It holds up to DEPTH fetched instructions with their PC and compressed flag, and presents the oldest to decode in first-word-fall-through order. A branch flush from decode discards every buffered entry in one cycle.

## Interface
Parameters:
- XLEN, 64, width of PC
- DEPTH, 4, number of entries; power of two, ≥ 2
- CW, $clog2(DEPTH)+1, width of count_o (derived, not overridable)

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  reset is asynchronous and active-high
- in_valid_i  input  1  fetch presents an instruction
- in_ready_o  output  1  buffer can accept; equals !full
- in_inst_i  input  32  instruction word, raw or compressed, as fetched
- in_pc_i  input  XLEN  PC of in_inst_i
- in_compressed_i  input  1  in_inst_i is a 16-bit RVC encoding
- out_valid_o  output  1  head entry valid
- out_ready_i  input  1  decode consumes head this cycle; driven low by decode on load_use
- out_inst_o  output  32  head instruction, or NOP when empty
- out_pc_o  output  XLEN  head PC, or 0 when empty
- out_compressed_o  output  1  head compressed flag, or 0 when empty
- flush_i  input  1  branch_flush from decode; discard all entries
- count_o  output  CW  occupancy, 0..DEPTH
- flush_cnt_o  output  32  saturating count of entries discarded by flushes (debug)

## Operation
- Storage: DEPTH-entry array of {inst[31:0], pc[XLEN-1:0], compressed}. Pointers: wr_ptr and rd_ptr, each $clog2(DEPTH) bits. Occupancy register: count.
- push = in_valid_i & in_ready_o & !flush_i.
- pop = out_valid_o & out_ready_i & !flush_i.
- Push writes array[wr_ptr]; wr_ptr increments modulo DEPTH and wraps naturally at DEPTH-1 → 0.
- Pop advances rd_ptr modulo DEPTH.
- count: next = count + push − pop. Simultaneous push and pop leaves count unchanged.
- Full: count == DEPTH. Then in_ready_o = 0. A pop in the same cycle does not re-open the input that cycle; there is no pass-through when full.
- Empty: count == 0. Then:
  - out_valid_o = 0;
  - out_inst_o = `INST_NOP` (32'h0000_0013, addi x0,x0,0), so the decoder never sees an illegal opcode;
  - out_pc_o = 0 and out_compressed_o = 0.
- Non-empty: outputs are driven combinationally from array[rd_ptr].
- Flush (flush_i = 1):
  - At the next edge: count ← 0, rd_ptr ← wr_ptr.
  - Any push or pop requested in the flush cycle is ignored.
  - flush_cnt_o += count, saturating at 2^32−1.
- Flush and reset are the only ways entries are removed other than pop.
- Array contents are not reset; validity is tracked by count alone.

## Timing
- Reset values, asynchronous: count 0, wr_ptr 0, rd_ptr 0, flush_cnt_o 0.
- Outputs after reset: in_ready_o 1, out_valid_o 0, out_inst_o 32'h13, out_pc_o 0, out_compressed_o 0.
- Latency: a push at edge N is visible on out_* after edge N; out_valid_o is high in cycle N+1. No same-cycle bypass from in_* to out_*.
- Pop: the next entry appears on out_* the cycle after the consuming edge.
- Handshake: out_* must hold stable while out_valid_o = 1 and out_ready_i = 0. in_* is sampled only when in_valid_i & in_ready_o.
- Flush in cycle N: out_valid_o = 0 and count_o = 0 from cycle N+1. A push accepted at N+1 is visible at N+2.
- Reset asserted mid-operation: all state clears immediately, asynchronously; the first push after deassertion behaves as from empty.
- in_ready_o, out_valid_o and count_o depend only on registered state, not on same-cycle inputs.

## Structure
- Add `INST_NOP` to define.v alongside the existing opcode macros.
- Derive pointer width from DEPTH; no other shared constants.
- One sub-module is natural: `ibuf_mem`, a DEPTH×(33+XLEN) register array with one write port and one asynchronous read port. Pointer and count logic stay in id_ibuf.

## Test plan
- Reset, then push inst 32'h00500093 at pc 0x80000000 → next cycle: out_valid_o = 1, out_inst_o = 32'h00500093, out_pc_o = 0x80000000, count_o = 1.
- Push 4 instructions with out_ready_i = 0 (DEPTH = 4) → count_o = 4, in_ready_o = 0. A fifth push is ignored. Draining returns the four in order.
- Continuous push+pop for 10 cycles → count_o stays constant, pointers wrap, PCs emerge in sequence 0x80000000, +4, …
- Fill 3 entries, assert flush_i together with in_valid_i → next cycle count_o = 0, out_inst_o = 32'h13, flush_cnt_o = 3, and the flush-cycle push is lost.
- Hold out_ready_i = 0 for 5 cycles (load-use stall) with the head at pc 0x80000010 → out_* stable throughout; releasing it pops exactly one entry.
- Assert reset asynchronously mid-fill with count_o = 2 → count_o = 0 and out_valid_o = 0 without waiting for a clock edge.

Source files
------------

// File: rtl/id_ibuf_pkg.sv
// Shared constants and helpers for the fetch-to-decode instruction buffer.
package id_ibuf_pkg;

   localparam logic [31:0] INST_NOP = 32'h0000_0013;

   function automatic logic [31:0] sat_add32(
      input logic [31:0] a,
      input logic [31:0] b
   );
      logic [32:0] s;
      s = {1'b0, a} + {1'b0, b};
      return s[32] ? 32'hFFFF_FFFF : s[31:0];
   endfunction

endpackage

// File: rtl/id_ibuf_mem.sv
// Register array for the instruction buffer: one write port, one async read.
module ibuf_mem #(
   parameter int DEPTH = 4,
   parameter int W     = 97,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic          clock,
   input  logic          we_i,
   input  logic [AW-1:0] waddr_i,
   input  logic [W-1:0]  wdata_i,
   input  logic [AW-1:0] raddr_i,
   output logic [W-1:0]  rdata_o
);

   logic [W-1:0] mem_q [DEPTH];

   // No reset: entry validity lives entirely in the occupancy count.
   always_ff @(posedge clock) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/id_ibuf.sv
// First-word-fall-through instruction buffer between fetch and decode,
// with single-cycle flush of all buffered entries.
module id_ibuf
   import id_ibuf_pkg::*;
#(
   parameter int XLEN  = 64,
   parameter int DEPTH = 4,
   localparam int CW   = $clog2(DEPTH) + 1
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            in_valid_i,
   output logic            in_ready_o,
   input  logic [31:0]     in_inst_i,
   input  logic [XLEN-1:0] in_pc_i,
   input  logic            in_compressed_i,
   output logic            out_valid_o,
   input  logic            out_ready_i,
   output logic [31:0]     out_inst_o,
   output logic [XLEN-1:0] out_pc_o,
   output logic            out_compressed_o,
   input  logic            flush_i,
   output logic [CW-1:0]   count_o,
   output logic [31:0]     flush_cnt_o
);

   localparam int PW = $clog2(DEPTH);
   localparam int EW = 33 + XLEN;

   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic [31:0]   flush_cnt_q, flush_cnt_d;

   logic          full, empty, push, pop;
   logic [EW-1:0] wdata, rdata;

   assign full  = (count_q == CW'(DEPTH));
   assign empty = (count_q == '0);

   assign in_ready_o  = !full;
   assign out_valid_o = !empty;

   assign push = in_valid_i & in_ready_o & !flush_i;
   assign pop  = out_valid_o & out_ready_i & !flush_i;

   assign wdata = {in_compressed_i, in_pc_i, in_inst_i};

   ibuf_mem #(
      .DEPTH(DEPTH),
      .W    (EW)
   ) u_mem (
      .clock  (clock),
      .we_i   (push),
      .waddr_i(wr_ptr_q),
      .wdata_i(wdata),
      .raddr_i(rd_ptr_q),
      .rdata_o(rdata)
   );

   always_comb begin
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      flush_cnt_d = flush_cnt_q;
      if (flush_i) begin
         rd_ptr_d    = wr_ptr_q;
         count_d     = '0;
         flush_cnt_d = sat_add32(flush_cnt_q, 32'(count_q));
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
         case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         flush_cnt_q <= '0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   // Empty buffer presents a harmless NOP rather than stale array data.
   assign out_inst_o       = empty ? INST_NOP : rdata[31:0];
   assign out_pc_o         = empty ? '0 : rdata[32 +: XLEN];
   assign out_compressed_o = empty ? 1'b0 : rdata[EW-1];

   assign count_o     = count_q;
   assign flush_cnt_o = flush_cnt_q;

endmodule

// File: tb/tb_id_ibuf.sv
// Directed self-checking bench for id_ibuf (XLEN=64, DEPTH=4).
module tb_id_ibuf;

   localparam int XLEN = 64;
   localparam int CW   = 3;
   localparam logic [63:0] BASE = 64'h8000_0000;

   logic            clock = 1'b0;
   logic            reset = 1'b0;
   logic            in_valid_i = 1'b0;
   logic            in_ready_o;
   logic [31:0]     in_inst_i = '0;
   logic [XLEN-1:0] in_pc_i = '0;
   logic            in_compressed_i = 1'b0;
   logic            out_valid_o;
   logic            out_ready_i = 1'b0;
   logic [31:0]     out_inst_o;
   logic [XLEN-1:0] out_pc_o;
   logic            out_compressed_o;
   logic            flush_i = 1'b0;
   logic [CW-1:0]   count_o;
   logic [31:0]     flush_cnt_o;

   int checks = 0;
   int errors = 0;

   id_ibuf #(
      .XLEN (XLEN),
      .DEPTH(4)
   ) dut (
      .clock           (clock),
      .reset           (reset),
      .in_valid_i      (in_valid_i),
      .in_ready_o      (in_ready_o),
      .in_inst_i       (in_inst_i),
      .in_pc_i         (in_pc_i),
      .in_compressed_i (in_compressed_i),
      .out_valid_o     (out_valid_o),
      .out_ready_i     (out_ready_i),
      .out_inst_o      (out_inst_o),
      .out_pc_o        (out_pc_o),
      .out_compressed_o(out_compressed_o),
      .flush_i         (flush_i),
      .count_o         (count_o),
      .flush_cnt_o     (flush_cnt_o)
   );

   always #5 clock = ~clock;

   task automatic chk(
      input string       tag,
      input logic [63:0] obs,
      input logic [63:0] exp
   );
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic push(
      input logic [31:0] inst,
      input logic [63:0] pc,
      input logic        c
   );
      in_valid_i      = 1'b1;
      in_inst_i       = inst;
      in_pc_i         = pc;
      in_compressed_i = c;
      step();
      in_valid_i      = 1'b0;
   endtask

   initial begin
      // Reset state
      #2 reset = 1'b1;
      #2;
      chk("rst_in_ready", 64'(in_ready_o), 64'd1);
      chk("rst_out_valid", 64'(out_valid_o), 64'd0);
      chk("rst_out_inst", 64'(out_inst_o), 64'h13);
      chk("rst_out_pc", out_pc_o, 64'd0);
      chk("rst_out_c", 64'(out_compressed_o), 64'd0);
      chk("rst_count", 64'(count_o), 64'd0);
      chk("rst_flush_cnt", 64'(flush_cnt_o), 64'd0);
      step();
      reset = 1'b0;
      step();

      // Single push, visible next cycle
      push(32'h0050_0093, BASE, 1'b0);
      chk("p1_valid", 64'(out_valid_o), 64'd1);
      chk("p1_inst", 64'(out_inst_o), 64'h0050_0093);
      chk("p1_pc", out_pc_o, BASE);
      chk("p1_count", 64'(count_o), 64'd1);
      out_ready_i = 1'b1;
      step();
      out_ready_i = 1'b0;
      chk("p1_pop_count", 64'(count_o), 64'd0);
      chk("p1_pop_valid", 64'(out_valid_o), 64'd0);

      // Fill to full, overflow attempt, drain in order
      for (int i = 0; i < 4; i++)
         push(32'h100 + 32'(i), BASE + 64'h100 + 64'(4 * i), i[0]);
      chk("full_count", 64'(count_o), 64'd4);
      chk("full_ready", 64'(in_ready_o), 64'd0);
      push(32'hDEAD_BEEF, 64'h1234, 1'b1);
      chk("ovf_count", 64'(count_o), 64'd4);
      chk("ovf_head_pc", out_pc_o, BASE + 64'h100);
      out_ready_i = 1'b1;
      for (int i = 0; i < 4; i++) begin
         chk("drain_inst", 64'(out_inst_o), 64'h100 + 64'(i));
         chk("drain_pc", out_pc_o, BASE + 64'h100 + 64'(4 * i));
         chk("drain_c", 64'(out_compressed_o), 64'(i % 2));
         step();
      end
      out_ready_i = 1'b0;
      chk("drain_count", 64'(count_o), 64'd0);
      chk("drain_inst_nop", 64'(out_inst_o), 64'h13);

      // Streaming push+pop across pointer wrap
      push(32'h0000_0113, BASE, 1'b0);
      out_ready_i = 1'b1;
      in_valid_i  = 1'b1;
      for (int k = 0; k < 10; k++) begin
         in_inst_i = 32'h0000_0113;
         in_pc_i   = BASE + 64'(4 * (k + 1));
         chk("strm_pc", out_pc_o, BASE + 64'(4 * k));
         chk("strm_count", 64'(count_o), 64'd1);
         step();
      end
      in_valid_i = 1'b0;
      chk("strm_last_pc", out_pc_o, BASE + 64'd40);
      step();
      out_ready_i = 1'b0;
      chk("strm_end_count", 64'(count_o), 64'd0);

      // Flush with 3 entries plus a same-cycle push
      for (int i = 0; i < 3; i++)
         push(32'h200 + 32'(i), BASE + 64'h200 + 64'(4 * i), 1'b0);
      chk("pre_flush_count", 64'(count_o), 64'd3);
      flush_i    = 1'b1;
      in_valid_i = 1'b1;
      in_inst_i  = 32'h0BAD_0BAD;
      in_pc_i    = 64'hBAD0;
      step();
      flush_i    = 1'b0;
      in_valid_i = 1'b0;
      chk("fl_count", 64'(count_o), 64'd0);
      chk("fl_valid", 64'(out_valid_o), 64'd0);
      chk("fl_inst", 64'(out_inst_o), 64'h13);
      chk("fl_cnt", 64'(flush_cnt_o), 64'd3);
      push(32'h0000_0213, BASE + 64'h300, 1'b1);
      chk("post_fl_valid", 64'(out_valid_o), 64'd1);
      chk("post_fl_pc", out_pc_o, BASE + 64'h300);
      chk("post_fl_c", 64'(out_compressed_o), 64'd1);
      chk("post_fl_count", 64'(count_o), 64'd1);
      out_ready_i = 1'b1;
      step();
      out_ready_i = 1'b0;

      // Load-use stall holds head stable
      push(32'h00A0_0513, BASE + 64'h10, 1'b0);
      push(32'h00B0_0593, BASE + 64'h14, 1'b0);
      for (int s = 0; s < 5; s++) begin
         chk("stall_pc", out_pc_o, BASE + 64'h10);
         chk("stall_inst", 64'(out_inst_o), 64'h00A0_0513);
         chk("stall_count", 64'(count_o), 64'd2);
         step();
      end
      out_ready_i = 1'b1;
      step();
      out_ready_i = 1'b0;
      chk("rel_pc", out_pc_o, BASE + 64'h14);
      chk("rel_count", 64'(count_o), 64'd1);

      // Asynchronous reset mid-fill
      push(32'h00C0_0613, BASE + 64'h18, 1'b0);
      chk("pre_rst_count", 64'(count_o), 64'd2);
      #2 reset = 1'b1;
      #1;
      chk("arst_count", 64'(count_o), 64'd0);
      chk("arst_valid", 64'(out_valid_o), 64'd0);
      chk("arst_flush_cnt", 64'(flush_cnt_o), 64'd0);
      #1 reset = 1'b0;
      step();
      push(32'h00D0_0693, BASE + 64'h40, 1'b0);
      chk("after_rst_count", 64'(count_o), 64'd1);
      chk("after_rst_pc", out_pc_o, BASE + 64'h40);
      chk("after_rst_inst", 64'(out_inst_o), 64'h00D0_0693);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
